conn_table_loader: RTL
======================

Name: conn_table_loader

Overview:
- Parametrised successor to the single-record configuration reader.
- Bulk-loads a binary connection table from ROM into an internal record store: header first, then all records back-to-back.
- Reads are pipelined at one word per cycle against a configurable fixed ROM read latency.
- Afterwards serves random-access record queries with a valid/ready handshake and fixed 1-cycle latency; sits between the config ROM and the RDMA connection manager.

Parameters:
- MAX_CONNECTIONS, 64, record store depth; power of two.
- WORDS_PER_CONN, 11, 32-bit words per record.
- HDR_WORDS, 4, header words: magic, version, count, timestamp. Must be ≥ 4.
- MEM_LATENCY, 1, cycles from mem_rd_en to valid mem_rdata; 1..4.
- BASE_ADDR, 0, byte address of header word 0.
- ADDR_WIDTH, 32, ROM byte-address width.
- IDX_W, $clog2(MAX_CONNECTIONS), query index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_rd_en  out  1  ROM read strobe, one word per asserted cycle.
- mem_addr  out  ADDR_WIDTH  ROM byte address.
- mem_rdata  in  32  ROM data, valid MEM_LATENCY cycles after the strobe.
- start  in  1  level-sampled load request.
- busy  out  1  load in progress.
- load_done  out  1  one-cycle pulse on successful load.
- table_valid  out  1  store holds a verified table.
- error_code  out  2  0 none, 1 bad magic, 2 count > MAX_CONNECTIONS, 3 count == 0.
- hdr_version  out  32  captured header version.
- hdr_count  out  32  captured header count.
- hdr_timestamp  out  32  captured header timestamp.
- table_checksum  out  32  XOR of all record words loaded.
- query_valid  in  1  query request.
- query_ready  out  1  equals table_valid && !busy.
- query_index  in  IDX_W  record index.
- resp_valid  out  1  one-cycle response strobe.
- resp_error  out  1  index ≥ hdr_count.
- resp_record  out  32*WORDS_PER_CONN  record; word 0 at LSBs.

Behaviour:
- Reset: all outputs 0. State IDLE. Counters and pipeline cleared. Store contents need not be reset.
- States: IDLE, HDR_RD, HDR_CHK, TBL_RD, READY, ERROR.
- IDLE/READY/ERROR with start=1: next state HDR_RD.
  - Clear table_valid, error_code, table_checksum. busy=1 from the next cycle.
  - start in any other state is ignored.
- HDR_RD:
  - Issue HDR_WORDS consecutive reads at BASE_ADDR+4*i, one per cycle, no gaps.
  - A MEM_LATENCY-deep valid shift register tags returns; capture index counts returns independently of the issue index.
  - Move to HDR_CHK when the last header word is captured.
- HDR_CHK (1 cycle): checks in priority order magic ≠ 32'h41544746 → code 1; count > MAX_CONNECTIONS → code 2; count == 0 → code 3.
  - Any failure → ERROR.
  - Pass → TBL_RD. Total = count*WORDS_PER_CONN, computed in 32 bits.
- TBL_RD:
  - Word w is read at BASE_ADDR + 4*HDR_WORDS + 4*w.
  - Store slot is (w / WORDS_PER_CONN, w % WORDS_PER_CONN), kept as record/word counters; no divider.
  - Each captured word is XORed into table_checksum.
  - After the last capture: READY, load_done=1 for one cycle, table_valid=1, busy=0.
- ERROR: busy=0, table_valid=0, error_code held until the next start.
- Reads issue back-to-back. Header load takes HDR_WORDS+MEM_LATENCY cycles; table load takes total+MEM_LATENCY cycles.
- Query handshake:
  - Accepted when query_valid && query_ready.
  - resp_valid is asserted exactly the next cycle, with resp_record = the stored record and resp_error=0.
  - Out-of-range index: resp_error=1, resp_record=0.
  - Queries while not ready get no response; the requester holds query_valid.
- Query and start in the same READY cycle: start wins, query not accepted (query_ready drops combinationally on start).
- Reset mid-load: immediate return to IDLE, all outputs 0.
- No reads are issued outside HDR_RD/TBL_RD. mem_addr holds its last value otherwise.

Decomposition:
- Package conn_cfg_pkg holds:
  - magic constant 32'h41544746;
  - header word offsets (magic 0, version 1, count 2, timestamp 3);
  - error_code localparams;
  - state enum encoding.
- One sub-module: conn_rd_pipe.
  - Issues reads from a start address and word count.
  - Emits return-valid after MEM_LATENCY with a capture index.
  - Used for both the header phase and the table phase.

Test Plan:
- Valid header (count=3, MEM_LATENCY=1) plus 33 known words:
  - load_done after 4+1+1+33+1 cycles (±1 stated in bench);
  - table_valid=1, hdr_count=3, table_checksum = XOR of the 33 words.
- Same image at MEM_LATENCY=3: identical store contents and checksum; busy 4 cycles longer.
- Magic 32'h12345678 → ERROR, error_code=1, no TBL_RD reads issued. Count=65 → code 2. Count=0 → code 3.
- After load, query index 2 → resp_valid the next cycle, resp_record word0 = record 2 switch_id. Query index 5 with count=3 → resp_error=1.
- Back-to-back queries 0,1,2 on consecutive cycles → three consecutive responses in order.
- Assert rst_n=0 mid-TBL_RD, then restart → clean reload. A start pulse during load is ignored: exactly one load_done.

Source files
------------

// File: rtl/conn_cfg_pkg.sv
// Shared constants for the connection-table loader: header layout, error codes
// and the loader FSM encoding.
package conn_cfg_pkg;

  localparam logic [31:0] CONN_MAGIC = 32'h41544746;

  localparam int unsigned HDR_OFS_MAGIC   = 0;
  localparam int unsigned HDR_OFS_VERSION = 1;
  localparam int unsigned HDR_OFS_COUNT   = 2;
  localparam int unsigned HDR_OFS_TSTAMP  = 3;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_BAD_MAGIC  = 2'd1;
  localparam logic [1:0] ERR_COUNT_BIG  = 2'd2;
  localparam logic [1:0] ERR_COUNT_ZERO = 2'd3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HDR_RD  = 3'd1;
  localparam state_t ST_HDR_CHK = 3'd2;
  localparam state_t ST_TBL_RD  = 3'd3;
  localparam state_t ST_READY   = 3'd4;
  localparam state_t ST_ERROR   = 3'd5;

endpackage

// File: rtl/conn_rd_pipe.sv
// Back-to-back ROM read issuer: one word per cycle from a start address, with a
// latency-matched valid shift register tagging each returning word by index.
module conn_rd_pipe #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           word_count,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  ret_valid,
  output logic [31:0]           ret_index,
  output logic                  ret_last
);

  logic [31:0]            issue_left;
  logic [31:0]            total;
  logic [MEM_LATENCY-1:0] vld_sr;

  // Issue side and return side run independently; the capture index only
  // advances on returning words, so it lags the issue address by the latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      issue_left <= '0;
      total      <= '0;
      ret_index  <= '0;
      vld_sr     <= '0;
    end else begin
      if (go) begin
        mem_rd_en  <= (word_count != 32'd0);
        mem_addr   <= base_addr;
        issue_left <= word_count - 32'd1;
        total      <= word_count;
      end else if (mem_rd_en) begin
        if (issue_left == 32'd0) begin
          mem_rd_en <= 1'b0;
        end else begin
          mem_addr   <= mem_addr + ADDR_WIDTH'(4);
          issue_left <= issue_left - 32'd1;
        end
      end
      vld_sr <= (vld_sr << 1) | MEM_LATENCY'(mem_rd_en);
      if (go) begin
        ret_index <= '0;
      end else if (ret_valid) begin
        ret_index <= ret_index + 32'd1;
      end
    end
  end

  assign ret_valid = vld_sr[MEM_LATENCY-1];
  assign ret_last  = ret_valid && (ret_index == total - 32'd1);

endmodule

// File: rtl/conn_table_loader.sv
// Connection-table loader: pulls header and records from config ROM, validates
// the header, then serves single-cycle record lookups to the connection manager.
module conn_table_loader
  import conn_cfg_pkg::*;
#(
  parameter int MAX_CONNECTIONS = 64,
  parameter int WORDS_PER_CONN  = 11,
  parameter int HDR_WORDS       = 4,
  parameter int MEM_LATENCY     = 1,
  parameter int ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int IDX_W           = $clog2(MAX_CONNECTIONS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        mem_rd_en,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic [31:0]                 mem_rdata,
  input  logic                        start,
  output logic                        busy,
  output logic                        load_done,
  output logic                        table_valid,
  output logic [1:0]                  error_code,
  output logic [31:0]                 hdr_version,
  output logic [31:0]                 hdr_count,
  output logic [31:0]                 hdr_timestamp,
  output logic [31:0]                 table_checksum,
  input  logic                        query_valid,
  output logic                        query_ready,
  input  logic [IDX_W-1:0]            query_index,
  output logic                        resp_valid,
  output logic                        resp_error,
  output logic [32*WORDS_PER_CONN-1:0] resp_record
);

  localparam int WW = (WORDS_PER_CONN > 1) ? $clog2(WORDS_PER_CONN) : 1;
  localparam logic [ADDR_WIDTH-1:0] TBL_BASE = BASE_ADDR + ADDR_WIDTH'(4 * HDR_WORDS);

  state_t                state;
  logic [31:0]           hdr_magic;
  logic [31:0]           total_words;
  logic [1:0]            chk_code;
  logic [IDX_W-1:0]      rec_cnt;
  logic [WW-1:0]         word_cnt;
  logic [31:0]           store [MAX_CONNECTIONS][WORDS_PER_CONN];
  logic                  start_acc;
  logic                  tbl_go;
  logic                  pipe_go;
  logic                  ret_valid;
  logic                  ret_last;
  logic [31:0]           ret_index;
  logic [31:0]           pipe_count;
  logic [ADDR_WIDTH-1:0] pipe_base;
  logic                  query_acc;

  assign start_acc   = start && (state == ST_IDLE || state == ST_READY || state == ST_ERROR);
  assign tbl_go      = (state == ST_HDR_CHK) && (chk_code == ERR_NONE);
  assign pipe_go     = start_acc || tbl_go;
  assign pipe_base   = start_acc ? BASE_ADDR : TBL_BASE;
  assign total_words = hdr_count * 32'(WORDS_PER_CONN);
  assign pipe_count  = start_acc ? 32'(HDR_WORDS) : total_words;
  assign query_ready = table_valid && !busy && !start;
  assign query_acc   = query_valid && query_ready;

  always_comb begin
    chk_code = ERR_NONE;
    if (hdr_magic != CONN_MAGIC) begin
      chk_code = ERR_BAD_MAGIC;
    end else if (hdr_count > 32'(MAX_CONNECTIONS)) begin
      chk_code = ERR_COUNT_BIG;
    end else if (hdr_count == 32'd0) begin
      chk_code = ERR_COUNT_ZERO;
    end
  end

  conn_rd_pipe #(
    .MEM_LATENCY(MEM_LATENCY),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (pipe_go),
    .base_addr (pipe_base),
    .word_count(pipe_count),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .ret_valid (ret_valid),
    .ret_index (ret_index),
    .ret_last  (ret_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      load_done      <= 1'b0;
      table_valid    <= 1'b0;
      error_code     <= ERR_NONE;
      hdr_magic      <= '0;
      hdr_version    <= '0;
      hdr_count      <= '0;
      hdr_timestamp  <= '0;
      table_checksum <= '0;
      rec_cnt        <= '0;
      word_cnt       <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        ST_IDLE, ST_READY, ST_ERROR: begin
          if (start) begin
            state          <= ST_HDR_RD;
            busy           <= 1'b1;
            table_valid    <= 1'b0;
            error_code     <= ERR_NONE;
            table_checksum <= '0;
          end
        end
        ST_HDR_RD: begin
          if (ret_valid) begin
            if (ret_index == HDR_OFS_MAGIC)   hdr_magic     <= mem_rdata;
            if (ret_index == HDR_OFS_VERSION) hdr_version   <= mem_rdata;
            if (ret_index == HDR_OFS_COUNT)   hdr_count     <= mem_rdata;
            if (ret_index == HDR_OFS_TSTAMP)  hdr_timestamp <= mem_rdata;
            if (ret_last) state <= ST_HDR_CHK;
          end
        end
        ST_HDR_CHK: begin
          if (chk_code != ERR_NONE) begin
            error_code <= chk_code;
            busy       <= 1'b0;
            state      <= ST_ERROR;
          end else begin
            rec_cnt  <= '0;
            word_cnt <= '0;
            state    <= ST_TBL_RD;
          end
        end
        ST_TBL_RD: begin
          if (ret_valid) begin
            table_checksum <= table_checksum ^ mem_rdata;
            // Record/word counters replace a divide of the flat word index.
            if (word_cnt == WW'(WORDS_PER_CONN - 1)) begin
              word_cnt <= '0;
              rec_cnt  <= rec_cnt + IDX_W'(1);
            end else begin
              word_cnt <= word_cnt + WW'(1);
            end
            if (ret_last) begin
              state       <= ST_READY;
              busy        <= 1'b0;
              load_done   <= 1'b1;
              table_valid <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_TBL_RD && ret_valid) begin
      store[rec_cnt][word_cnt] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_error  <= 1'b0;
      resp_record <= '0;
    end else begin
      resp_valid <= query_acc;
      if (query_acc) begin
        if (32'(query_index) >= hdr_count) begin
          resp_error  <= 1'b1;
          resp_record <= '0;
        end else begin
          resp_error <= 1'b0;
          for (int w = 0; w < WORDS_PER_CONN; w++) begin
            resp_record[w*32 +: 32] <= store[query_index][w];
          end
        end
      end
    end
  end

endmodule
